// File: rtl/sys_mem_responder_if.sv
// sys_mem_responder_if
//   System-side bus between a cache (master) and its backing memory (slave).
//   Strobe/RW/Address/Data/Ready handshake:
//     MemStrobe   master -> slave  request valid
//     MemRW       master -> slave  1 = read, 0 = write
//     MemAddress  master -> slave  word address
//     MemWData    master -> slave  write data
//     MemRData    slave -> master  read data, held until the next read completes
//     MemReady    slave -> master  one-cycle completion pulse
interface sys_mem_responder_if;
  logic        MemStrobe;
  logic        MemRW;
  logic [31:0] MemAddress;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemReady;

  modport master (
    output MemStrobe, MemRW, MemAddress, MemWData,
    input  MemRData, MemReady
  );

  modport slave (
    input  MemStrobe, MemRW, MemAddress, MemWData,
    output MemRData, MemReady
  );
endinterface

// File: rtl/sys_mem_responder.sv
// sys_mem_responder
//   Word-addressed backing memory answering a cache system bus with a fixed,
//   programmable number of wait states. Keeps completed read/write counters.
//   Ports:
//     clock        rising-edge clock
//     reset        asynchronous, active-low reset
//     bus          slave side of sys_mem_responder_if
//     busy         high whenever the FSM is not IDLE
//     read_count   completed reads, wraps modulo 2^16
//     write_count  completed writes, wraps modulo 2^16
//   Parameters:
//     ADDR_WIDTH   word-index bits (depth 2**ADDR_WIDTH words); upper address bits alias
//     LATENCY      wait cycles between acceptance and the Ready pulse (>= 0)
module sys_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  sys_mem_responder_if.slave   bus,
  output logic                 busy,
  output logic [15:0]          read_count,
  output logic [15:0]          write_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  // Not reset: contents survive reset.
  logic [31:0] mem [2**ADDR_WIDTH];

  state_t                  state;
  logic [CW-1:0]           wait_cnt;
  logic                    rw_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             wdata_reg;

  logic                    accept;
  logic                    rd_fire;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  // Upper address bits alias by design; latched write data is only a debug
  // copy because the write commits at acceptance from the bus itself.
  logic addr_unused;
  logic wdata_unused;
  assign addr_unused  = ^bus.MemAddress[31:ADDR_WIDTH];
  assign wdata_unused = ^wdata_reg;

  assign accept = (state == IDLE) && bus.MemStrobe;

  // Array read happens on the edge that enters RESP. With no wait states that
  // edge is the acceptance edge itself, so the address comes straight off the bus.
  assign rd_fire = ((state == WAIT) && (wait_cnt == '0) && rw_reg) ||
                   ((LATENCY == 0) && accept && bus.MemRW);
  assign rd_addr = (state == IDLE) ? bus.MemAddress[ADDR_WIDTH-1:0] : addr_reg;

  // Write port: commits at acceptance, so a following read sees the new data.
  // Gated by reset so bus activity while in reset cannot touch the array.
  always_ff @(posedge clock) begin
    if (reset && accept && !bus.MemRW) begin
      mem[bus.MemAddress[ADDR_WIDTH-1:0]] <= bus.MemWData;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      rw_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      bus.MemReady <= 1'b0;
      bus.MemRData <= '0;
      busy         <= 1'b0;
      read_count   <= '0;
      write_count  <= '0;
    end else begin
      if (rd_fire) begin
        bus.MemRData <= mem[rd_addr];
      end

      case (state)
        IDLE: begin
          bus.MemReady <= 1'b0;
          if (accept) begin
            rw_reg    <= bus.MemRW;
            addr_reg  <= bus.MemAddress[ADDR_WIDTH-1:0];
            wdata_reg <= bus.MemWData;
            busy      <= 1'b1;
            if (LATENCY > 0) begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state        <= RESP;
              bus.MemReady <= 1'b1;
            end
          end
        end

        // Bus inputs are ignored here; a dropped strobe does not abort.
        WAIT: begin
          if (wait_cnt == '0) begin
            state        <= RESP;
            bus.MemReady <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        RESP: begin
          bus.MemReady <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
          if (rw_reg) begin
            read_count <= read_count + 16'd1;
          end else begin
            write_count <= write_count + 16'd1;
          end
        end

        default: begin
          state        <= IDLE;
          bus.MemReady <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_mem_responder.sv
// tb_sys_mem_responder
//   Directed bench for sys_mem_responder. Two instances share clock/reset:
//   dut_a with LATENCY = 2 and dut_b with LATENCY = 0, both ADDR_WIDTH = 10.
//   Inputs are driven 1 time unit after a rising edge and outputs are sampled
//   at the same point, away from the active edge.
module tb_sys_mem_responder;

  logic        clock;
  logic        reset;
  logic        busy_a, busy_b;
  logic [15:0] rc_a, wc_a, rc_b, wc_b;

  int checks = 0;
  int errors = 0;

  sys_mem_responder_if bus_a();
  sys_mem_responder_if bus_b();

  sys_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus_a.slave),
    .busy        (busy_a),
    .read_count  (rc_a),
    .write_count (wc_a)
  );

  sys_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus_b.slave),
    .busy        (busy_b),
    .read_count  (rc_b),
    .write_count (wc_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input bit sel, input logic stb, input logic rw,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (sel) begin
      bus_b.MemStrobe = stb; bus_b.MemRW = rw; bus_b.MemAddress = addr; bus_b.MemWData = wd;
    end else begin
      bus_a.MemStrobe = stb; bus_a.MemRW = rw; bus_a.MemAddress = addr; bus_a.MemWData = wd;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.MemReady : bus_a.MemReady;
  endfunction

  function automatic logic [31:0] rdata(input bit sel);
    return sel ? bus_b.MemRData : bus_a.MemRData;
  endfunction

  function automatic logic bsy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // One complete transaction, starting 1 unit after a rising edge with the DUT
  // in IDLE. exp_edges = rising edges from strobe presentation to Ready seen.
  task automatic xfer(input bit sel, input logic rw, input logic [31:0] addr,
                      input logic [31:0] wd, input int exp_edges,
                      input logic [31:0] exp_rdata, input string tag);
    int n;
    set_bus(sel, 1'b1, rw, addr, wd);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!rdy(sel) && n < 20);
    check({tag, " ready_edges"}, n, exp_edges);
    check({tag, " busy_in_resp"}, {31'd0, bsy(sel)}, 32'd1);
    if (rw) check({tag, " rdata"}, rdata(sel), exp_rdata);
    set_bus(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    check({tag, " ready_single"}, {31'd0, rdy(sel)}, 32'd0);
    check({tag, " busy_after"}, {31'd0, bsy(sel)}, 32'd0);
    if (rw) check({tag, " rdata_held"}, rdata(sel), exp_rdata);
    $display("xfer %s dut=%0d rw=%0d addr=%h edges=%0d rdata=%h", tag, sel, rw, addr, n, rdata(sel));
  endtask

  logic [31:0] held_exp_a [3];
  logic [31:0] held_exp_b [3];

  initial begin
    int n;
    reset = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_bus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset held with random bus activity: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      set_bus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      set_bus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      check("rst ready_a", {31'd0, bus_a.MemReady}, 32'd0);
      check("rst busy_a", {31'd0, busy_a}, 32'd0);
      check("rst rdata_a", bus_a.MemRData, 32'd0);
      check("rst counts_a", {rc_a, wc_a}, 32'd0);
      check("rst ready_b", {31'd0, bus_b.MemReady}, 32'd0);
      check("rst counts_b", {rc_b, wc_b}, 32'd0);
      $display("reset cycle %0d ready_a=%0d busy_a=%0d ready_b=%0d", i, bus_a.MemReady, busy_a, bus_b.MemReady);
    end
    set_bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_bus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // LATENCY = 2: write then read, Ready 3 edges after strobe presentation.
    xfer(1'b0, 1'b0, 32'h005, 32'hDEADBEEF, 3, 32'h0, "a_wr_005");
    xfer(1'b0, 1'b1, 32'h005, 32'h0, 3, 32'hDEADBEEF, "a_rd_005");
    check("a counts after wr/rd", {rc_a, wc_a}, {16'd1, 16'd1});

    // Aliasing: 0x405 maps onto word 0x005.
    xfer(1'b0, 1'b0, 32'h405, 32'h12345678, 3, 32'h0, "a_wr_405");
    xfer(1'b0, 1'b1, 32'h005, 32'h0, 3, 32'h12345678, "a_rd_alias");

    // Preload for the held-strobe run, including a decoy at 0x3FF.
    xfer(1'b0, 1'b0, 32'h001, 32'hA1A1A1A1, 3, 32'h0, "a_wr_001");
    xfer(1'b0, 1'b0, 32'h002, 32'hB2B2B2B2, 3, 32'h0, "a_wr_002");
    xfer(1'b0, 1'b0, 32'h003, 32'hC3C3C3C3, 3, 32'h0, "a_wr_003");
    xfer(1'b0, 1'b0, 32'h3FF, 32'hFFFF0000, 3, 32'h0, "a_wr_3ff");

    // Held strobe: three reads, address scribbled to 0x3FF right after accept.
    held_exp_a[0] = 32'hA1A1A1A1;
    held_exp_a[1] = 32'hB2B2B2B2;
    held_exp_a[2] = 32'hC3C3C3C3;
    set_bus(1'b0, 1'b1, 1'b1, 32'h001, 32'h0);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clock); #1;
        n++;
        if (n == ((k == 0) ? 1 : 2)) bus_a.MemAddress = 32'h3FF;
      end while (!bus_a.MemReady && n < 20);
      check("a_held ready_edges", n, (k == 0) ? 3 : 4);
      check("a_held rdata", bus_a.MemRData, held_exp_a[k]);
      $display("held_a read %0d edges=%0d rdata=%h", k, n, bus_a.MemRData);
      if (k < 2) bus_a.MemAddress = 32'(k + 2);
    end
    set_bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    check("a counts after held", {rc_a, wc_a}, {16'd5, 16'd6});

    // LATENCY = 0: Ready one edge after presentation, every 2 edges when held.
    xfer(1'b1, 1'b0, 32'h010, 32'hCAFEF00D, 1, 32'h0, "b_wr_010");
    xfer(1'b1, 1'b0, 32'h011, 32'h0BADF00D, 1, 32'h0, "b_wr_011");
    xfer(1'b1, 1'b1, 32'h010, 32'h0, 1, 32'hCAFEF00D, "b_rd_010");
    held_exp_b[0] = 32'h0BADF00D;
    held_exp_b[1] = 32'hCAFEF00D;
    held_exp_b[2] = 32'h0BADF00D;
    set_bus(1'b1, 1'b1, 1'b1, 32'h011, 32'h0);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clock); #1;
        n++;
      end while (!bus_b.MemReady && n < 20);
      check("b_held ready_edges", n, (k == 0) ? 1 : 2);
      check("b_held rdata", bus_b.MemRData, held_exp_b[k]);
      $display("held_b read %0d edges=%0d rdata=%h", k, n, bus_b.MemRData);
      bus_b.MemAddress = (k == 0) ? 32'h010 : 32'h011;
    end
    set_bus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    check("b counts after held", {rc_b, wc_b}, {16'd4, 16'd2});

    // Reset in the middle of a WAIT: aborts silently, array survives.
    set_bus(1'b0, 1'b1, 1'b1, 32'h005, 32'h0);
    @(posedge clock); #1;
    check("a_abort busy_in_wait", {31'd0, busy_a}, 32'd1);
    set_bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("a_abort busy_now", {31'd0, busy_a}, 32'd0);
    check("a_abort ready_now", {31'd0, bus_a.MemReady}, 32'd0);
    check("a_abort read_count", {16'd0, rc_a}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("a_abort no_ready", {31'd0, bus_a.MemReady}, 32'd0);
    end
    $display("reset mid-request busy_a=%0d ready_a=%0d rc_a=%0d", busy_a, bus_a.MemReady, rc_a);
    reset = 1'b1;
    xfer(1'b0, 1'b1, 32'h005, 32'h0, 3, 32'h12345678, "a_rd_after_rst");
    check("a counts after rst", {rc_a, wc_a}, {16'd1, 16'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
